// File: rtl/muldiv_unit_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : muldiv_unit_pkg
// Purpose  : Shared constants and state encoding for the RV32M mul/div engine.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
package muldiv_unit_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] F3_MUL    = 3'b000;
    localparam logic [2:0] F3_MULH   = 3'b001;
    localparam logic [2:0] F3_MULHSU = 3'b010;
    localparam logic [2:0] F3_MULHU  = 3'b011;
    localparam logic [2:0] F3_DIV    = 3'b100;
    localparam logic [2:0] F3_DIVU   = 3'b101;
    localparam logic [2:0] F3_REM    = 3'b110;
    localparam logic [2:0] F3_REMU   = 3'b111;

    localparam logic [XLEN-1:0] DIV_BY_ZERO_Q = '1;
    localparam logic [XLEN-1:0] INT_MIN       = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_MUL  = 2'd1,
        ST_DIV  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/muldiv_unit_div_core.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : div_core
// Purpose  : Iterative unsigned restoring divider, one quotient bit per cycle.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module div_core
    import muldiv_unit_pkg::*;
#(
    parameter int WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0] r_count;
    logic             r_active;
    logic [WIDTH-1:0] r_rem;
    logic [WIDTH-1:0] r_quo;
    logic [WIDTH-1:0] r_div;

    logic [WIDTH:0]   w_shift;
    logic             w_ge;

    // quotient/remainder are the values after this cycle's step; busy drops
    // during the final step so the finished result can be taken the same cycle.
    assign w_shift   = {r_rem, r_quo[WIDTH-1]};
    assign w_ge      = (w_shift >= {1'b0, r_div});
    assign remainder = w_ge ? WIDTH'(w_shift - {1'b0, r_div}) : w_shift[WIDTH-1:0];
    assign quotient  = {r_quo[WIDTH-2:0], w_ge};
    assign busy      = r_active && (r_count != C_LAST);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count  <= '0;
            r_active <= 1'b0;
            r_rem    <= '0;
            r_quo    <= '0;
            r_div    <= '0;
        end else if (load) begin
            r_count  <= '0;
            r_active <= 1'b1;
            r_rem    <= '0;
            r_quo    <= dividend;
            r_div    <= divisor;
        end else if (r_active) begin
            r_rem   <= remainder;
            r_quo   <= quotient;
            r_count <= r_count + CNT_W'(1);
            if (r_count == C_LAST) begin
                r_active <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/muldiv_unit.sv
`default_nettype none
// ----------------------------------------------------------------------------
// Module   : muldiv_unit
// Purpose  : Execute-stage RV32M multiply/divide engine with pipeline stall.
// Revision : 1.0  initial release
// ----------------------------------------------------------------------------
module muldiv_unit
    import muldiv_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start_e,
    input  logic [2:0]      funct3_e,
    input  logic [XLEN-1:0] src_a_e,
    input  logic [XLEN-1:0] src_b_e,
    input  logic            flush_e,
    output logic            stall_req,
    output logic            done,
    output logic [XLEN-1:0] result
);

    state_t            r_state;
    state_t            w_state_next;
    logic [2:0]        r_funct3;
    logic [XLEN-1:0]   r_a;
    logic [XLEN-1:0]   r_b;
    logic              r_neg_q;
    logic              r_neg_r;

    logic              w_issue;
    logic              w_is_div;
    logic              w_div_signed;
    logic              w_a_neg;
    logic              w_b_neg;
    logic              w_div_zero;
    logic              w_div_ovf;
    logic              w_div_load;
    logic [XLEN-1:0]   w_a_mag;
    logic [XLEN-1:0]   w_b_mag;
    logic [XLEN-1:0]   w_special;

    logic              w_div_busy;
    logic [XLEN-1:0]   w_quotient;
    logic [XLEN-1:0]   w_remainder;
    logic [XLEN-1:0]   w_div_res;

    logic              w_a_sx;
    logic              w_b_sx;
    logic [2*XLEN-1:0] w_op_a;
    logic [2*XLEN-1:0] w_op_b;
    logic [2*XLEN-1:0] w_prod;
    logic [XLEN-1:0]   w_mul_res;

    assign w_issue      = (r_state == ST_IDLE) && start_e && !flush_e;
    assign w_is_div     = funct3_e[2];
    assign w_div_signed = !funct3_e[0];
    assign w_a_neg      = w_div_signed && src_a_e[XLEN-1];
    assign w_b_neg      = w_div_signed && src_b_e[XLEN-1];
    assign w_a_mag      = w_a_neg ? -src_a_e : src_a_e;
    assign w_b_mag      = w_b_neg ? -src_b_e : src_b_e;
    assign w_div_zero   = (src_b_e == '0);
    assign w_div_ovf    = w_div_signed && (src_a_e == INT_MIN) && (src_b_e == '1);
    assign w_div_load   = w_issue && w_is_div && !w_div_zero && !w_div_ovf;

    // funct3[1] separates remainder ops from quotient ops
    always_comb begin
        w_special = '0;
        if (w_div_zero) begin
            w_special = funct3_e[1] ? src_a_e : DIV_BY_ZERO_Q;
        end else begin
            w_special = funct3_e[1] ? '0 : INT_MIN;
        end
    end

    // Low 2*XLEN bits of the product of sign/zero-extended operands.
    assign w_a_sx    = r_a[XLEN-1] && ((r_funct3 == F3_MULH) || (r_funct3 == F3_MULHSU));
    assign w_b_sx    = r_b[XLEN-1] && (r_funct3 == F3_MULH);
    assign w_op_a    = {{XLEN{w_a_sx}}, r_a};
    assign w_op_b    = {{XLEN{w_b_sx}}, r_b};
    assign w_prod    = w_op_a * w_op_b;
    assign w_mul_res = (r_funct3 == F3_MUL) ? w_prod[XLEN-1:0] : w_prod[2*XLEN-1:XLEN];

    assign w_div_res = ((r_funct3 == F3_REM) || (r_funct3 == F3_REMU))
                     ? (r_neg_r ? -w_remainder : w_remainder)
                     : (r_neg_q ? -w_quotient  : w_quotient);

    div_core #(
        .WIDTH (XLEN)
    ) u_div_core (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (w_div_load),
        .dividend  (w_a_mag),
        .divisor   (w_b_mag),
        .busy      (w_div_busy),
        .quotient  (w_quotient),
        .remainder (w_remainder)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        stall_req    = 1'b0;
        done         = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_issue) begin
                    stall_req = 1'b1;
                    if (!w_is_div) begin
                        w_state_next = ST_MUL;
                    end else if (w_div_load) begin
                        w_state_next = ST_DIV;
                    end else begin
                        w_state_next = ST_DONE;
                    end
                end
            end
            ST_MUL: begin
                stall_req    = 1'b1;
                w_state_next = ST_DONE;
            end
            ST_DIV: begin
                stall_req = 1'b1;
                if (!w_div_busy) begin
                    w_state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                done         = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
        if (flush_e) begin
            stall_req    = 1'b0;
            w_state_next = ST_IDLE;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_funct3 <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_neg_q  <= 1'b0;
            r_neg_r  <= 1'b0;
            result   <= '0;
        end else if (w_issue) begin
            r_funct3 <= funct3_e;
            r_a      <= src_a_e;
            r_b      <= src_b_e;
            r_neg_q  <= w_a_neg ^ w_b_neg;
            r_neg_r  <= w_a_neg;
            if (w_is_div && !w_div_load) begin
                result <= w_special;
            end
        end else if (!flush_e) begin
            if (r_state == ST_MUL) begin
                result <= w_mul_res;
            end else if ((r_state == ST_DIV) && !w_div_busy) begin
                result <= w_div_res;
            end
        end
    end

endmodule
`default_nettype wire
